// File: rtl/xcorr_pkg.sv
// Shared definitions for the cross-correlation controller: width derivation,
// FSM state encoding and the L1 magnitude helper.
package xcorr_pkg;

    // Widest sample the magnitude helper accepts; callers sign-extend into it.
    localparam int MAG_IN_W = 64;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_PRIME  = 3'd1;
    localparam state_t S_STREAM = 3'd2;
    localparam state_t S_WAIT   = 3'd3;
    localparam state_t S_SCAN   = 3'd4;
    localparam state_t S_DONE   = 3'd5;

    function automatic int data_width(input int int_bits, input int fract_bits);
        return int_bits + fract_bits;
    endfunction

    function automatic int addr_width(input int nfft);
        return $clog2(nfft);
    endfunction

    // |re| + |im| with one guard bit, so the most negative input stays exact.
    function automatic logic [MAG_IN_W:0] l1_mag(input logic signed [MAG_IN_W-1:0] re,
                                                 input logic signed [MAG_IN_W-1:0] im);
        logic [MAG_IN_W:0] abs_re;
        logic [MAG_IN_W:0] abs_im;
        abs_re = re[MAG_IN_W-1] ? ({1'b0, ~re} + {{MAG_IN_W{1'b0}}, 1'b1}) : {1'b0, re};
        abs_im = im[MAG_IN_W-1] ? ({1'b0, ~im} + {{MAG_IN_W{1'b0}}, 1'b1}) : {1'b0, im};
        return abs_re + abs_im;
    endfunction

endpackage

// File: rtl/xcorr_peak_finder.sv
// Running maximum of the L1 magnitude over a scanned frame; max_o/idx_o
// already include the sample presented this cycle.
module xcorr_peak_finder
    import xcorr_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int AW         = 7
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         valid_i,
    input  logic [AW-1:0]                idx_i,
    input  logic signed [DATA_WIDTH-1:0] re_i,
    input  logic signed [DATA_WIDTH-1:0] im_i,
    output logic [DATA_WIDTH:0]          max_o,
    output logic [AW-1:0]                idx_o
);

    localparam int MW = DATA_WIDTH + 1;

    logic [DATA_WIDTH:0] max_q;
    logic [AW-1:0]       idx_q;
    logic [DATA_WIDTH:0] mag;
    logic                upd;

    assign mag   = MW'(l1_mag(MAG_IN_W'(re_i), MAG_IN_W'(im_i)));
    // Strictly greater: ties keep the earlier (lower) index.
    assign upd   = valid_i && (mag > max_q);
    assign max_o = upd ? mag : max_q;
    assign idx_o = upd ? idx_i : idx_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            max_q <= '0;
            idx_q <= '0;
        end else if (clear_i) begin
            max_q <= '0;
            idx_q <= '0;
        end else begin
            max_q <= max_o;
            idx_q <= idx_o;
        end
    end

endmodule

// File: rtl/xcorr_ctrl.sv
// Sequencer for one cross-correlation run: streams a sample frame into the
// xcorr core, waits for its result frame and reports the L1 peak.
module xcorr_ctrl
    import xcorr_pkg::*;
#(
    parameter int INTEGER_SIZE = 16,
    parameter int FRACT_SIZE   = 16,
    parameter int NFFT         = 128,
    parameter int TIMEOUT      = 1024,
    localparam int DATA_WIDTH  = data_width(INTEGER_SIZE, FRACT_SIZE),
    localparam int AW          = addr_width(NFFT)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         timeout_err_o,
    output logic                         rd_en_o,
    output logic [AW-1:0]                rd_addr_o,
    input  logic signed [DATA_WIDTH-1:0] mem1_r_i,
    input  logic signed [DATA_WIDTH-1:0] mem1_i_i,
    input  logic signed [DATA_WIDTH-1:0] mem2_r_i,
    input  logic signed [DATA_WIDTH-1:0] mem2_i_i,
    output logic                         core_start_o,
    output logic [DATA_WIDTH-1:0]        core_in1_r_o,
    output logic [DATA_WIDTH-1:0]        core_in1_i_o,
    output logic [DATA_WIDTH-1:0]        core_in2_r_o,
    output logic [DATA_WIDTH-1:0]        core_in2_i_o,
    input  logic signed [DATA_WIDTH-1:0] core_out_r_i,
    input  logic signed [DATA_WIDTH-1:0] core_out_i_i,
    input  logic                         core_end_ifft_i,
    output logic [AW-1:0]                peak_idx_o,
    output logic [DATA_WIDTH:0]          peak_mag_o
);

    // state  | meaning
    // IDLE   | waiting for start; address 0 is read in the accepting cycle
    // PRIME  | address 1 read; sample 0 lands on core_in next cycle
    // STREAM | cnt_q = sample index on core_in; reads run two ahead
    // WAIT   | core computing; down-timer bounds the wait
    // SCAN   | cnt_q = index of core output sample being scanned
    // DONE   | one-cycle completion pulse

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] CNT_LAST    = AW'(NFFT - 1);
    localparam logic [AW-1:0] RD_LAST_CNT = AW'(NFFT - 3);
    localparam logic [TW-1:0] TMR_LOAD    = TW'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic [TW-1:0]       tmr_q, tmr_d;
    logic                err_q, err_d;
    logic [AW-1:0]       peak_idx_q, peak_idx_d;
    logic [DATA_WIDTH:0] peak_mag_q, peak_mag_d;
    logic                rd_vld_q;
    logic                core_start_q;
    logic [DATA_WIDTH-1:0] in1_r_q, in1_i_q, in2_r_q, in2_i_q;

    logic                start_acc;
    logic                scan_vld;
    logic [AW-1:0]       scan_idx;
    logic [DATA_WIDTH:0] pf_max;
    logic [AW-1:0]       pf_idx;

    // rst_ni gates the accept so rd_en stays low while reset is asserted.
    assign start_acc = (state_q == S_IDLE) && start_i && rst_ni;
    assign scan_vld  = ((state_q == S_WAIT) && core_end_ifft_i) || (state_q == S_SCAN);
    assign scan_idx  = (state_q == S_SCAN) ? cnt_q : '0;

    always_comb begin
        rd_en_o   = 1'b0;
        rd_addr_o = '0;
        case (state_q)
            S_IDLE:  rd_en_o = start_acc;
            S_PRIME: begin
                rd_en_o   = 1'b1;
                rd_addr_o = AW'(1);
            end
            S_STREAM: if (cnt_q <= RD_LAST_CNT) begin
                rd_en_o   = 1'b1;
                rd_addr_o = cnt_q + AW'(2);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tmr_d      = tmr_q;
        err_d      = err_q;
        peak_idx_d = peak_idx_q;
        peak_mag_d = peak_mag_q;
        case (state_q)
            S_IDLE: if (start_acc) begin
                state_d = S_PRIME;
                err_d   = 1'b0;
            end
            S_PRIME: begin
                state_d = S_STREAM;
                cnt_d   = '0;
            end
            S_STREAM: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_WAIT;
                    tmr_d   = TMR_LOAD;
                end
            end
            S_WAIT: begin
                if (core_end_ifft_i) begin
                    state_d = S_SCAN;
                    cnt_d   = AW'(1);
                end else if (tmr_q == '0) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_SCAN: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d    = S_DONE;
                    peak_idx_d = pf_idx;
                    peak_mag_d = pf_max;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            tmr_q        <= '0;
            err_q        <= 1'b0;
            peak_idx_q   <= '0;
            peak_mag_q   <= '0;
            rd_vld_q     <= 1'b0;
            core_start_q <= 1'b0;
            in1_r_q      <= '0;
            in1_i_q      <= '0;
            in2_r_q      <= '0;
            in2_i_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tmr_q        <= tmr_d;
            err_q        <= err_d;
            peak_idx_q   <= peak_idx_d;
            peak_mag_q   <= peak_mag_d;
            rd_vld_q     <= rd_en_o;
            core_start_q <= (state_q == S_PRIME);
            if (rd_vld_q) begin
                in1_r_q <= mem1_r_i;
                in1_i_q <= mem1_i_i;
                in2_r_q <= mem2_r_i;
                in2_i_q <= mem2_i_i;
            end else begin
                in1_r_q <= '0;
                in1_i_q <= '0;
                in2_r_q <= '0;
                in2_i_q <= '0;
            end
        end
    end

    xcorr_peak_finder #(
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (AW)
    ) u_peak (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (start_acc),
        .valid_i (scan_vld),
        .idx_i   (scan_idx),
        .re_i    (core_out_r_i),
        .im_i    (core_out_i_i),
        .max_o   (pf_max),
        .idx_o   (pf_idx)
    );

    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE);
    assign timeout_err_o = done_o && err_q;
    assign core_start_o  = core_start_q;
    assign core_in1_r_o  = in1_r_q;
    assign core_in1_i_o  = in1_i_q;
    assign core_in2_r_o  = in2_r_q;
    assign core_in2_i_o  = in2_i_q;
    assign peak_idx_o    = peak_idx_q;
    assign peak_mag_o    = peak_mag_q;

endmodule

// File: tb/tb_xcorr_ctrl.sv
// Scoreboard bench for xcorr_ctrl: stimulus pushes expected core_start/done
// events, a negedge monitor pops and compares them and checks the sample stream.
module tb_xcorr_ctrl;

    localparam int NFFT = 128;
    localparam int DW   = 32;
    localparam int AW   = 7;

    typedef struct {
        int          cyc;
        logic        err;
        int          idx;
        longint      mag;
    } done_t;

    logic                 clk_i = 1'b0;
    logic                 rst_ni = 1'b0;
    logic                 start = 1'b0;
    logic                 busy, done, terr, rd_en, core_start, core_end = 1'b0;
    logic [AW-1:0]        rd_addr, peak_idx;
    logic [DW:0]          peak_mag;
    logic signed [DW-1:0] mem1_r, mem1_i, mem2_r, mem2_i;
    logic [DW-1:0]        in1_r, in1_i, in2_r, in2_i;
    logic signed [DW-1:0] out_r = '0, out_i = '0;
    logic signed [DW-1:0] fr_r [NFFT];
    logic signed [DW-1:0] fr_i [NFFT];

    int    cyc = 0;
    int    mem_a = 0;
    int    n_vec = 0;
    int    n_err = 0;
    int    start_q [$];
    done_t done_q [$];

    xcorr_ctrl dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .start_i         (start),
        .busy_o          (busy),
        .done_o          (done),
        .timeout_err_o   (terr),
        .rd_en_o         (rd_en),
        .rd_addr_o       (rd_addr),
        .mem1_r_i        (mem1_r),
        .mem1_i_i        (mem1_i),
        .mem2_r_i        (mem2_r),
        .mem2_i_i        (mem2_i),
        .core_start_o    (core_start),
        .core_in1_r_o    (in1_r),
        .core_in1_i_o    (in1_i),
        .core_in2_r_o    (in2_r),
        .core_in2_i_o    (in2_i),
        .core_out_r_i    (out_r),
        .core_out_i_i    (out_i),
        .core_end_ifft_i (core_end),
        .peak_idx_o      (peak_idx),
        .peak_mag_o      (peak_mag)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;
    always @(posedge clk_i) if (rd_en) mem_a <= int'(rd_addr);

    assign mem1_r = mem_a;
    assign mem1_i = mem_a + 1000;
    assign mem2_r = -mem_a - 1;
    assign mem2_i = mem_a * 3;

    function automatic logic [127:0] exp_smp(input int k);
        int a;
        a = k;
        return {a, a + 1000, -a - 1, a * 3};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic clr_frame();
        for (int j = 0; j < NFFT; j++) begin
            fr_r[j] = '0;
            fr_i[j] = '0;
        end
    endtask

    task automatic serve_frame(input int e);
        for (int j = 0; j < NFFT; j++) begin
            goto(e + j);
            core_end = (j == 0);
            out_r    = fr_r[j];
            out_i    = fr_i[j];
        end
        goto(e + NFFT);
        core_end = 1'b0;
        out_r    = '0;
        out_i    = '0;
    endtask

    task automatic start_run(input int s);
        goto(s);
        start = 1'b1;
        #1;
        chk("rd_en_at_accept", rd_en, 1'b1);
        chk("rd_addr_at_accept", rd_addr, 0);
        goto(s + 1);
        start = 1'b0;
        chk("busy_after_accept", busy, 1'b1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_terr"}, terr, 1'b0);
        chk({tag, "_rd_en"}, rd_en, 1'b0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_core_start"}, core_start, 1'b0);
        chk({tag, "_core_in"}, {in1_r, in1_i, in2_r, in2_i}, 0);
        chk({tag, "_peak_idx"}, peak_idx, 0);
        chk({tag, "_peak_mag"}, peak_mag, 0);
    endtask

    // Monitor: stream check, core_start timing, done scoreboard, read sequencing.
    initial begin
        int  k = 0;
        int  rd_cnt = 0;
        bit  streaming = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                streaming = 1'b0;
                rd_cnt    = 0;
            end else begin
                if (rd_en) begin
                    chk("rd_addr_seq", rd_addr, rd_cnt);
                    rd_cnt++;
                end
                if (streaming) begin
                    k++;
                    if (k < NFFT) begin
                        chk($sformatf("sample_%0d", k), {in1_r, in1_i, in2_r, in2_i}, exp_smp(k));
                    end else begin
                        chk("core_in_zero_after_frame", {in1_r, in1_i, in2_r, in2_i}, 0);
                        streaming = 1'b0;
                    end
                end
                if (core_start) begin
                    if (start_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_core_start @cyc %0d: got 1 expected 0", cyc);
                    end else begin
                        chk("core_start_cycle", cyc, start_q.pop_front());
                    end
                    streaming = 1'b1;
                    k         = 0;
                    chk("sample_0", {in1_r, in1_i, in2_r, in2_i}, exp_smp(0));
                end
                if (terr && !done) chk("terr_without_done", terr, 1'b0);
                if (done) begin
                    if (done_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_done @cyc %0d: got 1 expected 0", cyc);
                    end else begin
                        done_t d;
                        d = done_q.pop_front();
                        chk("done_cycle", cyc, d.cyc);
                        chk("timeout_err", terr, d.err);
                        chk("peak_idx", peak_idx, d.idx);
                        chk("peak_mag", peak_mag, d.mag);
                        chk("reads_per_run", rd_cnt, NFFT);
                    end
                    rd_cnt = 0;
                end
            end
        end
    end

    initial begin
        int c0;
        clr_frame();
        goto(2);
        check_zero("reset");
        goto(3);
        rst_ni = 1'b1;

        // A: ramp stream, single peak re=+5 at j=37; start pulsed in DONE is ignored.
        c0 = 12;
        start_q.push_back(c0);
        done_q.push_back('{cyc: c0 + 555, err: 1'b0, idx: 37, mag: 5});
        fr_r[37] = 32'sd5;
        start_run(10);
        serve_frame(c0 + 427);
        start = 1'b1;
        goto(c0 + 556);
        start = 1'b0;
        chk("start_in_done_ignored", busy, 1'b0);
        goto(c0 + 557);
        chk("still_idle_after_done", busy, 1'b0);

        // end_IFFT in IDLE must not start anything.
        goto(575);
        core_end = 1'b1;
        goto(576);
        core_end = 1'b0;
        chk("end_ifft_in_idle", busy, 1'b0);

        // B: tie at magnitude 10 between j=4 (-7,+3) and j=90 (+10).
        clr_frame();
        fr_r[4]  = -32'sd7;
        fr_i[4]  = 32'sd3;
        fr_r[90] = 32'sd10;
        c0 = 582;
        start_q.push_back(c0);
        done_q.push_back('{cyc: c0 + 555, err: 1'b0, idx: 4, mag: 10});
        start_run(580);
        serve_frame(c0 + 427);

        // C: no end_IFFT in WAIT (one stray pulse in STREAM) -> timeout, peak held.
        c0 = 1152;
        start_q.push_back(c0);
        done_q.push_back('{cyc: c0 + 128 + 1024, err: 1'b1, idx: 4, mag: 10});
        start_run(1150);
        goto(c0 + 10);
        core_end = 1'b1;
        goto(c0 + 11);
        core_end = 1'b0;

        // D: reset at sample 50 of the stream.
        c0 = 2322;
        start_q.push_back(c0);
        start_run(2320);
        goto(c0 + 50);
        #1;
        rst_ni = 1'b0;
        #1;
        check_zero("midrun_reset");
        goto(2375);
        rst_ni = 1'b1;

        // F: clean run after reset; j=0 taken in the end_IFFT cycle wins a tie with j=5.
        clr_frame();
        fr_r[0] = 32'sd100;
        fr_i[5] = -32'sd100;
        c0 = 2392;
        start_q.push_back(c0);
        done_q.push_back('{cyc: c0 + 555, err: 1'b0, idx: 0, mag: 100});
        start_run(2390);
        serve_frame(c0 + 427);

        // E: start held high: all-zero frame, then a most-negative corner at j=127.
        clr_frame();
        c0 = 2962;
        start_q.push_back(c0);
        start_q.push_back(c0 + 558);
        done_q.push_back('{cyc: c0 + 555, err: 1'b0, idx: 0, mag: 0});
        done_q.push_back('{cyc: c0 + 558 + 555, err: 1'b0, idx: 127, mag: 64'h1_0000_0000});
        goto(2960);
        start = 1'b1;
        serve_frame(c0 + 427);
        fr_r[0]   = 32'sd1;
        fr_r[127] = 32'sh8000_0000;
        fr_i[127] = 32'sh8000_0000;
        goto(c0 + 559);
        start = 1'b0;
        serve_frame(c0 + 558 + 427);
        goto(c0 + 558 + 560);
        chk("idle_after_held_start", busy, 1'b0);

        goto(4100);
        chk("pending_core_start", start_q.size(), 0);
        chk("pending_done", done_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
